dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares one data memory port between num_cores_p cores on the mem_in_s/mem_out_s valid/yumi handshake. Sits between the core array and the data memory. Grants one core at a time, round-robin, and holds the grant through request acceptance and response acknowledge. Routes the response back only to the granted core.

Parameters:
num_cores_p, 4, number of requesting cores (2..16)
addr_width_p, 32, width of data memory address
idx_width_p, $clog2(num_cores_p), grant index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
core_req_i  in  num_cores_p x mem_in_s  per-core request bundle (write_data, valid, wen, byte_not_word, yumi)
core_addr_i  in  num_cores_p x addr_width_p  per-core data address
core_resp_o  out  num_cores_p x mem_out_s  per-core response bundle (read_data, valid, yumi)
to_mem_o  out  mem_in_s  request to data memory
mem_addr_o  out  addr_width_p  address to data memory
from_mem_i  in  mem_out_s  response from data memory
grant_idx_o  out  idx_width_p  current owner; valid when busy_o=1
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr_r=0, grant_idx_r=0. All core_resp_o are 0. to_mem_o='0, mem_addr_o=0, busy_o=0. An in-flight transaction is abandoned; memory is reset with the arbiter.
- States: IDLE, ISSUE, RESP.
- IDLE: pick the first core with core_req_i[k].valid=1, searching from rr_ptr_r upward with wrap modulo num_cores_p. Register it in grant_idx_r and go to ISSUE. With no requester, stay in IDLE. No signal reaches memory in IDLE, so a transaction adds 1 cycle of arbitration latency.
- ISSUE: to_mem_o mirrors core_req_i[g] (g=grant_idx_r) and mem_addr_o=core_addr_i[g].
  - from_mem_i.yumi=1: go to RESP, and core_resp_o[g].yumi=1 that cycle.
  - Granted core drops valid before yumi: abort to IDLE with no memory side effect, and rr_ptr_r advances.
- RESP: to_mem_o.valid=0, and write_data/wen/byte_not_word stay driven from core g.
  - core_resp_o[g].valid and read_data mirror from_mem_i.
  - to_mem_o.yumi=core_req_i[g].yumi.
  - from_mem_i.valid & core_req_i[g].yumi: transaction complete, rr_ptr_r<=(g+1) mod num_cores_p, go to IDLE.
- Same-cycle yumi and valid in ISSUE (zero-latency memory): treat as passing through RESP in that cycle. If core yumi is also 1, complete directly to IDLE.
- Non-granted cores always see core_resp_o[k]='0. Their requests stay pending and are never dropped.
- Fairness: each requester is granted within num_cores_p transactions.
- The pointer wraps from num_cores_p-1 to 0. A non-power-of-2 num_cores_p must never select an index >= num_cores_p.
- Stores complete the same way as loads: the memory returns valid and the core yumis.

Optional Feature:
DMEM_ARB_PERF_CNT_EN
- Defined: adds these ports:
  - grant_cnt_o, out, num_cores_p x 32: per-core count of completed transactions.
  - wait_cnt_o, out, num_cores_p x 32: per-core count of cycles with valid=1 while not granted.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; other behaviour identical.

Decomposition:
- Shared package (definitions.sv): arb_state_e {IDLE_A, ISSUE_A, RESP_A}, kept distinct from the core's state_e. Also a perf counter width constant.
- Sub-module dmem_arb_rr_picker: combinational, takes req vector + rr_ptr and returns found + index. It is reusable for barrier/network arbitration.

Test Plan:
- Single request: core 2 load, addr 0x40, memory yumi 1 cycle later, response 0xDEADBEEF after 3 cycles -> only core_resp_o[2] sees yumi then valid with 0xDEADBEEF. Returns to IDLE after core yumi, and rr_ptr=3.
- All 4 cores request continuously from reset -> grant order 0,1,2,3,0. Every core_resp_o[k] is 0 while not granted.
- Zero-latency memory (yumi and valid same cycle, core yumi held high) -> transaction completes in 2 cycles (IDLE, ISSUE). Next grant follows immediately.
- Core 1 store, byte_not_word=1, data 0x000000AB, addr 0x13 -> to_mem_o wen=1, byte_not_word=1, write_data=0xAB, mem_addr_o=0x13 while in ISSUE.
- Reset asserted in RESP -> next edge gives busy_o=0, all outputs 0, rr_ptr=0. A subsequent core 3 request is granted normally.
- Core 0 drops valid in ISSUE before memory yumi -> state returns to IDLE, memory sees no accepted request, and pending core 1 is granted next.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: memory handshake bundles, arbiter
// state encoding (distinct from the core's state_e) and perf counter width.
package dmem_arbiter_pkg;

   localparam int data_width_c     = 32;
   localparam int perf_cnt_width_c = 32;

   typedef struct packed {
      logic [data_width_c-1:0] write_data;
      logic                    valid;
      logic                    wen;
      logic                    byte_not_word;
      logic                    yumi;
   } mem_in_s;

   typedef struct packed {
      logic [data_width_c-1:0] read_data;
      logic                    valid;
      logic                    yumi;
   } mem_out_s;

   typedef enum logic [1:0] {IDLE_A, ISSUE_A, RESP_A} arb_state_e;

   // Single-subtract wrap; callers keep v < 2*n.
   function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
      return (v >= n) ? v - n : v;
   endfunction

endpackage

// File: rtl/dmem_arb_rr_picker.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i,
// wrapping modulo num_p. Never returns an index >= num_p.
module dmem_arb_rr_picker
   import dmem_arbiter_pkg::*;
#(
   parameter int num_p       = 4,
   parameter int idx_width_p = $clog2(num_p)
) (
   input  logic [num_p-1:0]       req_i,
   input  logic [idx_width_p-1:0] ptr_i,
   output logic                   found_o,
   output logic [idx_width_p-1:0] idx_o
);

   logic [idx_width_p-1:0] cand;

   // Scan from the far end so the candidate closest to ptr_i wins last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int i = num_p - 1; i >= 0; i--) begin
         cand = idx_width_p'(rr_wrap(32'(ptr_i) + 32'(i), 32'(num_p)));
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port among num_cores_p cores.
// Optional per-core perf counters when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int num_cores_p  = 4,
   parameter int addr_width_p = 32,
   parameter int idx_width_p  = $clog2(num_cores_p)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  mem_in_s  [num_cores_p-1:0]                 core_req_i,
   input  logic     [num_cores_p-1:0][addr_width_p-1:0] core_addr_i,
   output mem_out_s [num_cores_p-1:0]                 core_resp_o,
   output mem_in_s                                    to_mem_o,
   output logic     [addr_width_p-1:0]                mem_addr_o,
   input  mem_out_s                                   from_mem_i,
   output logic     [idx_width_p-1:0]                 grant_idx_o,
   output logic                                       busy_o
`ifdef DMEM_ARB_PERF_CNT_EN
   ,
   output logic [num_cores_p-1:0][perf_cnt_width_c-1:0] grant_cnt_o,
   output logic [num_cores_p-1:0][perf_cnt_width_c-1:0] wait_cnt_o
`endif
);

   arb_state_e             state_r, state_n;
   logic [idx_width_p-1:0] grant_idx_r, rr_ptr_r, rr_next, pick_idx;
   logic [num_cores_p-1:0] req_vld;
   logic                   pick_found, g_valid, g_yumi, accept, done, abort;

   always_comb begin
      req_vld = '0;
      for (int k = 0; k < num_cores_p; k++) req_vld[k] = core_req_i[k].valid;
   end

   dmem_arb_rr_picker #(.num_p(num_cores_p), .idx_width_p(idx_width_p)) u_picker (
      .req_i   (req_vld),
      .ptr_i   (rr_ptr_r),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign g_valid = core_req_i[grant_idx_r].valid;
   assign g_yumi  = core_req_i[grant_idx_r].yumi;
   assign accept  = g_valid & from_mem_i.yumi;
   assign rr_next = (grant_idx_r == idx_width_p'(num_cores_p - 1)) ? '0
                                                                   : grant_idx_r + idx_width_p'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE_A;
      else       state_r <= state_n;
   end

   // Accept with same-cycle response is treated as a pass through RESP.
   always_comb begin
      state_n = state_r;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state_r)
         IDLE_A: if (pick_found) state_n = ISSUE_A;
         ISSUE_A: begin
            if (!g_valid) begin
               abort   = 1'b1;
               state_n = IDLE_A;
            end else if (from_mem_i.yumi) begin
               if (from_mem_i.valid && g_yumi) begin
                  done    = 1'b1;
                  state_n = IDLE_A;
               end else begin
                  state_n = RESP_A;
               end
            end
         end
         RESP_A: begin
            if (from_mem_i.valid && g_yumi) begin
               done    = 1'b1;
               state_n = IDLE_A;
            end
         end
         default: state_n = IDLE_A;
      endcase
   end

   always_comb begin
      to_mem_o    = '0;
      mem_addr_o  = '0;
      core_resp_o = '0;
      unique case (state_r)
         ISSUE_A: begin
            to_mem_o                         = core_req_i[grant_idx_r];
            mem_addr_o                       = core_addr_i[grant_idx_r];
            core_resp_o[grant_idx_r].yumi    = accept;
            if (accept && from_mem_i.valid) begin
               core_resp_o[grant_idx_r].valid     = 1'b1;
               core_resp_o[grant_idx_r].read_data = from_mem_i.read_data;
            end
         end
         RESP_A: begin
            to_mem_o                           = core_req_i[grant_idx_r];
            to_mem_o.valid                     = 1'b0;
            mem_addr_o                         = core_addr_i[grant_idx_r];
            core_resp_o[grant_idx_r].valid     = from_mem_i.valid;
            core_resp_o[grant_idx_r].read_data = from_mem_i.read_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_idx_r <= '0;
         rr_ptr_r    <= '0;
      end else begin
         if (state_r == IDLE_A && pick_found) grant_idx_r <= pick_idx;
         if (done || abort)                   rr_ptr_r    <= rr_next;
      end
   end

   assign grant_idx_o = grant_idx_r;
   assign busy_o      = (state_r != IDLE_A);

`ifdef DMEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt_o <= '0;
         wait_cnt_o  <= '0;
      end else begin
         for (int k = 0; k < num_cores_p; k++) begin
            if (done && grant_idx_r == idx_width_p'(k) && !(&grant_cnt_o[k]))
               grant_cnt_o[k] <= grant_cnt_o[k] + perf_cnt_width_c'(1);
            if (core_req_i[k].valid && !(busy_o && grant_idx_r == idx_width_p'(k))
                && !(&wait_cnt_o[k]))
               wait_cnt_o[k] <= wait_cnt_o[k] + perf_cnt_width_c'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector tables plus hand sequences
// for store fields, abort, and reset during a response.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   mem_in_s  [3:0]        core_req;
   logic     [3:0][31:0]  core_addr;
   mem_out_s [3:0]        core_resp;
   mem_in_s               to_mem;
   logic     [31:0]       mem_addr;
   mem_out_s              from_mem;
   logic     [1:0]        grant_idx;
   logic                  busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.num_cores_p(4), .addr_width_p(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .core_req_i  (core_req),
      .core_addr_i (core_addr),
      .core_resp_o (core_resp),
      .to_mem_o    (to_mem),
      .mem_addr_o  (mem_addr),
      .from_mem_i  (from_mem),
      .grant_idx_o (grant_idx),
      .busy_o      (busy)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  cyumi;
      logic        myumi;
      logic        mvalid;
      logic [31:0] rdata;
      logic        ebusy;
      logic [1:0]  egrant;
      logic        etmv;
      logic [31:0] eaddr;
      logic        etmy;
      logic [3:0]  eryumi;
      logic [3:0]  ervalid;
   } vec_t;

   vec_t sr_tbl[12];
   vec_t rr_tbl[10];

   function automatic vec_t mk(logic [3:0] vld, logic [3:0] cy, logic my, logic mv,
                               logic [31:0] rd, logic eb, logic [1:0] eg, logic etmv,
                               logic [31:0] ea, logic etmy, logic [3:0] ery, logic [3:0] erv);
      vec_t v;
      v.vld = vld; v.cyumi = cy; v.myumi = my; v.mvalid = mv; v.rdata = rd;
      v.ebusy = eb; v.egrant = eg; v.etmv = etmv; v.eaddr = ea; v.etmy = etmy;
      v.eryumi = ery; v.ervalid = erv;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      core_req = '0;
      from_mem = '0;
      for (int k = 0; k < 4; k++) core_addr[k] = 32'(k * 32);
   endtask

   task automatic reset_dut();
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic edge_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v, input string nm);
      mem_out_s [3:0] er;
      edge_drive();
      for (int k = 0; k < 4; k++) begin
         core_req[k].valid = v.vld[k];
         core_req[k].yumi  = v.cyumi[k];
      end
      from_mem.yumi      = v.myumi;
      from_mem.valid     = v.mvalid;
      from_mem.read_data = v.rdata;
      @(negedge clk);
      er = '0;
      for (int k = 0; k < 4; k++) begin
         er[k].yumi      = v.eryumi[k];
         er[k].valid     = v.ervalid[k];
         er[k].read_data = v.ervalid[k] ? v.rdata : 32'h0;
      end
      chk({nm, " busy"}, 160'(busy), 160'(v.ebusy));
      if (v.ebusy) chk({nm, " grant"}, 160'(grant_idx), 160'(v.egrant));
      chk({nm, " to_mem.valid"}, 160'(to_mem.valid), 160'(v.etmv));
      chk({nm, " mem_addr"}, 160'(mem_addr), 160'(v.eaddr));
      chk({nm, " to_mem.yumi"}, 160'(to_mem.yumi), 160'(v.etmy));
      chk({nm, " core_resp"}, 160'(core_resp), 160'(er));
   endtask

   initial begin
      mem_out_s [3:0] er;
      mem_in_s        em;

      // Core 2 load, then cores 3 and 0 with zero-latency memory (wrap 3 -> 0).
      sr_tbl[0]  = mk(4'b0100, 4'b0000, 0, 0, 32'h0,        0, 0, 0, 32'h00, 0, 4'b0000, 4'b0000);
      sr_tbl[1]  = mk(4'b0100, 4'b0000, 0, 0, 32'h0,        1, 2, 1, 32'h40, 0, 4'b0000, 4'b0000);
      sr_tbl[2]  = mk(4'b0100, 4'b0000, 1, 0, 32'h0,        1, 2, 1, 32'h40, 0, 4'b0100, 4'b0000);
      sr_tbl[3]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        1, 2, 0, 32'h40, 0, 4'b0000, 4'b0000);
      sr_tbl[4]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        1, 2, 0, 32'h40, 0, 4'b0000, 4'b0000);
      sr_tbl[5]  = mk(4'b0000, 4'b0100, 0, 1, 32'hDEADBEEF, 1, 2, 0, 32'h40, 1, 4'b0000, 4'b0100);
      sr_tbl[6]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 0, 32'h00, 0, 4'b0000, 4'b0000);
      sr_tbl[7]  = mk(4'b1001, 4'b0000, 0, 0, 32'h0,        0, 0, 0, 32'h00, 0, 4'b0000, 4'b0000);
      sr_tbl[8]  = mk(4'b1001, 4'b1000, 1, 1, 32'h11111111, 1, 3, 1, 32'h60, 1, 4'b1000, 4'b1000);
      sr_tbl[9]  = mk(4'b0001, 4'b0001, 0, 0, 32'h0,        0, 0, 0, 32'h00, 0, 4'b0000, 4'b0000);
      sr_tbl[10] = mk(4'b0001, 4'b0001, 1, 1, 32'h22222222, 1, 0, 1, 32'h00, 1, 4'b0001, 4'b0001);
      sr_tbl[11] = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 0, 32'h00, 0, 4'b0000, 4'b0000);

      // All cores request, zero-latency memory: IDLE/ISSUE pairs granting 0,1,2,3,0.
      for (int j = 0; j < 10; j++) begin
         int g;
         g = (j / 2) % 4;
         if (j % 2 == 0)
            rr_tbl[j] = mk(4'hF, 4'hF, 1, 1, 32'hC0DE0000 + 32'(j), 0, 0, 0, 32'h0, 0, 4'h0, 4'h0);
         else
            rr_tbl[j] = mk(4'hF, 4'hF, 1, 1, 32'hC0DE0000 + 32'(j), 1, 2'(g), 1,
                           32'(g * 32), 1, 4'(1 << g), 4'(1 << g));
      end

      // Reset state
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      chk("reset busy", 160'(busy), 160'(0));
      chk("reset grant", 160'(grant_idx), 160'(0));
      chk("reset to_mem", 160'(to_mem), 160'(0));
      chk("reset mem_addr", 160'(mem_addr), 160'(0));
      chk("reset core_resp", 160'(core_resp), 160'(0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) apply_vec(sr_tbl[i], $sformatf("single[%0d]", i));

      reset_dut();
      for (int i = 0; i < 10; i++) apply_vec(rr_tbl[i], $sformatf("rr[%0d]", i));

      // Core 1 byte store: fields pass through in ISSUE and stay in RESP.
      reset_dut();
      edge_drive();
      core_req[1]  = '{write_data: 32'hAB, valid: 1'b1, wen: 1'b1, byte_not_word: 1'b1, yumi: 1'b0};
      core_addr[1] = 32'h13;
      @(negedge clk);
      chk("store idle busy", 160'(busy), 160'(0));
      edge_drive();
      @(negedge clk);
      em = '{write_data: 32'hAB, valid: 1'b1, wen: 1'b1, byte_not_word: 1'b1, yumi: 1'b0};
      chk("store issue to_mem", 160'(to_mem), 160'(em));
      chk("store issue addr", 160'(mem_addr), 160'(32'h13));
      chk("store issue grant", 160'(grant_idx), 160'(1));
      edge_drive();
      from_mem.yumi = 1'b1;
      @(negedge clk);
      er = '0;
      er[1].yumi = 1'b1;
      chk("store accept resp", 160'(core_resp), 160'(er));
      edge_drive();
      from_mem.yumi     = 1'b0;
      core_req[1].valid = 1'b0;
      @(negedge clk);
      em.valid = 1'b0;
      chk("store resp to_mem", 160'(to_mem), 160'(em));
      edge_drive();
      from_mem.valid     = 1'b1;
      from_mem.read_data = 32'h5A;
      core_req[1].yumi   = 1'b1;
      @(negedge clk);
      er = '0;
      er[1].valid     = 1'b1;
      er[1].read_data = 32'h5A;
      chk("store done resp", 160'(core_resp), 160'(er));
      chk("store done to_mem.yumi", 160'(to_mem.yumi), 160'(1));
      edge_drive();
      clear_inputs();
      @(negedge clk);
      chk("store back idle", 160'(busy), 160'(0));

      // Core 0 drops valid in ISSUE; pending core 1 is granted next.
      reset_dut();
      edge_drive();
      core_req[0].valid = 1'b1;
      core_req[1].valid = 1'b1;
      @(negedge clk);
      edge_drive();
      @(negedge clk);
      chk("abort grant0", 160'(grant_idx), 160'(0));
      edge_drive();
      core_req[0].valid = 1'b0;
      @(negedge clk);
      chk("abort to_mem.valid", 160'(to_mem.valid), 160'(0));
      chk("abort core_resp", 160'(core_resp), 160'(0));
      edge_drive();
      @(negedge clk);
      chk("abort idle", 160'(busy), 160'(0));
      edge_drive();
      @(negedge clk);
      chk("abort next busy", 160'(busy), 160'(1));
      chk("abort next grant", 160'(grant_idx), 160'(1));
      chk("abort next addr", 160'(mem_addr), 160'(32'h20));

      // Reset in RESP after rr_ptr has moved to 2: pointer must return to 0.
      reset_dut();
      edge_drive();
      core_req[1].valid = 1'b1;
      @(negedge clk);
      edge_drive();
      from_mem.yumi = 1'b1;
      @(negedge clk);
      edge_drive();
      from_mem.yumi     = 1'b0;
      core_req[1].valid = 1'b0;
      core_req[1].yumi  = 1'b1;
      from_mem.valid    = 1'b1;
      @(negedge clk);
      edge_drive();
      clear_inputs();
      core_req[2].valid = 1'b1;
      @(negedge clk);
      edge_drive();
      from_mem.yumi = 1'b1;
      @(negedge clk);
      edge_drive();
      from_mem.yumi      = 1'b0;
      core_req[2].valid  = 1'b0;
      from_mem.valid     = 1'b1;
      from_mem.read_data = 32'h55;
      @(negedge clk);
      chk("rst-resp pre busy", 160'(busy), 160'(1));
      #2 reset = 1'b1;
      #1;
      chk("rst-resp busy", 160'(busy), 160'(0));
      chk("rst-resp to_mem", 160'(to_mem), 160'(0));
      chk("rst-resp mem_addr", 160'(mem_addr), 160'(0));
      chk("rst-resp core_resp", 160'(core_resp), 160'(0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      clear_inputs();
      edge_drive();
      core_req[1].valid = 1'b1;
      core_req[3].valid = 1'b1;
      @(negedge clk);
      chk("post-rst idle", 160'(busy), 160'(0));
      edge_drive();
      @(negedge clk);
      chk("post-rst busy", 160'(busy), 160'(1));
      chk("post-rst grant", 160'(grant_idx), 160'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
